// File: rtl/wrr_arbiter.sv
// wrr_arbiter
//   Weighted round-robin arbiter with a registered one-hot grant and burst hold.
//   Whoever wins keeps the grant for up to weight[i] beats. A weight of 0 is
//   treated as 1. The arbiter picks again only when a burst ends. The search
//   starts at the requester after the last owner.
//
//   Optional feature macro: WRR_LOCK_EN. When it is defined, the lock input
//   exists. While lock and req[owner] are both high, the current burst is held.
//
// Ports
//   clk        clock, all state on posedge
//   rst        asynchronous active-high reset
//   req        request vector, level sensitive, bit i = requester i
//   weight     per-requester weight, field i = weight[i*WEIGHT_W +: WEIGHT_W]
//   lock       hold current grant (WRR_LOCK_EN only)
//   gnt        registered one-hot grant, all zero when idle
//   gnt_id     binary index of the grant owner, 0 when idle
//   gnt_valid  |gnt
//
// state | meaning
// IDLE  | no grant outstanding
// GRANT | gnt_id owns the resource, cnt = beats left after the current one
module wrr_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int WEIGHT_W = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*WEIGHT_W-1:0]   weight,
`ifdef WRR_LOCK_EN
    input  logic                          lock,
`endif
    output logic [NUM_REQ-1:0]            gnt,
    output logic [$clog2(NUM_REQ)-1:0]    gnt_id,
    output logic                          gnt_valid
);

    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t              state, state_n;
    logic [NUM_REQ-1:0]  gnt_n;
    logic [ID_W-1:0]     id_n;
    logic [ID_W-1:0]     ptr, ptr_n;
    logic [WEIGHT_W-1:0] cnt, cnt_n;

    logic                lock_eff;
    logic                burst_end;
    logic [ID_W-1:0]     nxt_ptr;
    logic [ID_W-1:0]     arb_ptr;
    logic [ID_W-1:0]     win;
    logic                win_found;
    logic [WEIGHT_W-1:0] w_sel;
    logic [WEIGHT_W-1:0] w_load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            gnt    <= '0;
            gnt_id <= '0;
            ptr    <= '0;
            cnt    <= '0;
        end else begin
            state  <= state_n;
            gnt    <= gnt_n;
            gnt_id <= id_n;
            ptr    <= ptr_n;
            cnt    <= cnt_n;
        end
    end

    assign gnt_valid = |gnt;

    always_comb begin
        state_n   = state;
        gnt_n     = gnt;
        id_n      = gnt_id;
        ptr_n     = ptr;
        cnt_n     = cnt;
        win       = '0;
        win_found = 1'b0;

`ifdef WRR_LOCK_EN
        lock_eff = lock;
`else
        lock_eff = 1'b0;
`endif

        // A burst always ends when the owner drops its request, even while locked.
        burst_end = !req[gnt_id] || ((cnt == '0) && !lock_eff);
        nxt_ptr   = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;

        // At a burst end, ptr moves on in this same cycle. The search therefore
        // uses the next pointer directly, so back-to-back grants have no bubble.
        arb_ptr = (state == GRANT) ? nxt_ptr : ptr;

        // Both loops run high to low, so the lowest matching index wins.
        // The masked pass overrides the unmasked one.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                win       = ID_W'(i);
                win_found = 1'b1;
            end
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i] && (ID_W'(i) >= arb_ptr)) begin
                win = ID_W'(i);
            end
        end

        w_sel  = weight[int'(win)*WEIGHT_W +: WEIGHT_W];
        w_load = (w_sel == '0) ? '0 : w_sel - 1'b1;

        case (state)
            IDLE: begin
                if (win_found) begin
                    state_n = GRANT;
                    gnt_n   = NUM_REQ'(1) << win;
                    id_n    = win;
                    cnt_n   = w_load;
                end
            end
            GRANT: begin
                if (burst_end) begin
                    ptr_n = nxt_ptr;
                    if (win_found) begin
                        gnt_n = NUM_REQ'(1) << win;
                        id_n  = win;
                        cnt_n = w_load;
                    end else begin
                        state_n = IDLE;
                        gnt_n   = '0;
                        id_n    = '0;
                        cnt_n   = '0;
                    end
                end else if (!lock_eff) begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
                id_n    = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_wrr_arbiter.sv
module tb_wrr_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [15:0] weight = '0;
    logic        lock = 1'b0;
    logic [3:0]  gnt;
    logic [1:0]  gnt_id;
    logic        gnt_valid;
    logic [3:0]  req_q = '0;

    int total = 0;
    int bad   = 0;

    wrr_arbiter #(.NUM_REQ(4), .WEIGHT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .weight    (weight),
`ifdef WRR_LOCK_EN
        .lock      (lock),
`endif
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        lock = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    // Expect a sequence of grants, one per cycle, each given as an owner index.
    task automatic expect_owners(input string tag, input int owners[], input int n);
        for (int k = 0; k < n; k++) begin
            step();
            chk(tag, {28'h0, gnt}, 32'(4'b0001 << owners[k]));
        end
    endtask

    always @(posedge clk) req_q <= req;

    always @(negedge clk) begin
        if (!rst) begin
            chk("onehot0", {31'h0, $onehot0(gnt)}, 32'd1);
            chk("valid_or", {31'h0, gnt_valid}, {31'h0, |gnt});
            if (gnt_valid) chk("gnt_at_id", {31'h0, gnt[gnt_id]}, 32'd1);
            chk("gnt_without_req", {28'h0, gnt & ~req_q}, 32'd0);
        end
    end

    initial begin
        // T1: reset values, async clear mid-grant, restart from ptr 0
        #1;
        chk("rst_gnt", {28'h0, gnt}, 32'd0);
        chk("rst_id", {30'h0, gnt_id}, 32'd0);
        chk("rst_valid", {31'h0, gnt_valid}, 32'd0);
        step();
        rst = 1'b0;
        weight = 16'h1111;
        req = 4'b1111;
        #1;
        chk("no_comb_path", {28'h0, gnt}, 32'd0);
        expect_owners("t1_pre", '{0, 1}, 2);
        rst = 1'b1;
        #1;
        chk("async_gnt", {28'h0, gnt}, 32'd0);
        chk("async_valid", {31'h0, gnt_valid}, 32'd0);
        step();
        rst = 1'b0;
        expect_owners("t1_post", '{0}, 1);

        // T2: weights all 1, rotation with no idle cycles
        do_reset();
        weight = 16'h1111;
        req = 4'b1111;
        expect_owners("t2_rot", '{0, 1, 2, 3, 0}, 5);

        // T3: weights {3,1,2,1}
        do_reset();
        weight = {4'd1, 4'd2, 4'd1, 4'd3};
        req = 4'b1111;
        expect_owners("t3_wrr", '{0, 0, 0, 1, 2, 2, 3, 0}, 8);
        chk("t3_id", {30'h0, gnt_id}, 32'd0);

        // T4: owner drops early; its unused weight is not carried over
        do_reset();
        weight = {4'd1, 4'd1, 4'd1, 4'd4};
        req = 4'b0101;
        expect_owners("t4_burst", '{0, 0}, 2);
        req = 4'b0100;
        expect_owners("t4_drop", '{2}, 1);
        req = 4'b0101;
        expect_owners("t4_fresh", '{0, 0, 0, 0, 2}, 5);

        // T5: weight 0 acts as 1, pointer wraps 3 -> 0
        do_reset();
        weight = {4'd0, 4'd1, 4'd1, 4'd2};
        req = 4'b1000;
        expect_owners("t5_own3", '{3}, 1);
        chk("t5_id3", {30'h0, gnt_id}, 32'd3);
        req = 4'b1001;
        expect_owners("t5_wrap", '{0, 0, 3, 0}, 4);

        // Sole requester re-wins without gaps; dropping all requests returns to idle
        do_reset();
        weight = {4'd1, 4'd1, 4'd2, 4'd1};
        req = 4'b0010;
        expect_owners("sole", '{1, 1, 1, 1, 1}, 5);
        req = 4'b0000;
        step();
        chk("idle_gnt", {28'h0, gnt}, 32'd0);
        chk("idle_id", {30'h0, gnt_id}, 32'd0);
        chk("idle_valid", {31'h0, gnt_valid}, 32'd0);

        // Mid-burst requests never preempt the owner
        do_reset();
        weight = {4'd1, 4'd1, 4'd3, 4'd1};
        req = 4'b0010;
        expect_owners("nopre_a", '{1}, 1);
        req = 4'b0011;
        expect_owners("nopre_b", '{1, 1, 0}, 3);

`ifdef WRR_LOCK_EN
        // T6: lock holds the burst; releasing lock ends it
        do_reset();
        weight = 16'h1111;
        req = 4'b0010;
        expect_owners("t6_get", '{1}, 1);
        req = 4'b0011;
        lock = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("t6_lock", {28'h0, gnt}, 32'b0010);
        end
        lock = 1'b0;
        expect_owners("t6_rel", '{0}, 1);
        // lock with owner request dropped still ends the burst
        lock = 1'b1;
        req = 4'b0010;
        expect_owners("t6_drop", '{1}, 1);
        lock = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
